// File: rtl/acc_pkg.sv
// acc_pkg
// Shared definitions for the accumulator/save-stack block.
//   op_t  : 4-bit opcode encoding driven on acc_stack.op
//   ACC_W : default accumulator and data bus width
package acc_pkg;

   localparam int ACC_W = 4;

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_LOAD   = 4'd1,
      OP_CLEAR  = 4'd2,
      OP_INC    = 4'd3,
      OP_DEC    = 4'd4,
      OP_SHL    = 4'd5,
      OP_SHR    = 4'd6,
      OP_PUSH   = 4'd7,
      OP_POP    = 4'd8,
      OP_CLRERR = 4'd9
   } op_t;

endpackage

// File: rtl/acc_stack_mem.sv
// acc_stack_mem
// DEPTH x WIDTH register array that holds saved accumulator values.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable, writes wdata to entry waddr on the clock edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
// The array has no reset; its contents are don't-care until written.
module acc_stack_mem #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] memArray [DEPTH];

   // Synchronous write port; the top never writes when the stack is full,
   // so waddr always addresses a real entry.
   always_ff @(posedge clk) begin
      if (we) begin
         memArray[waddr] <= wdata;
      end
   end

   // Combinational read so a POP can complete in the same cycle it is seen.
   assign rdata = memArray[raddr];

endmodule

// File: rtl/acc_stack.sv
// acc_stack
// WIDTH-bit accumulator with a DEPTH-entry save stack. One opcode is
// applied per clock: load, clear, increment, decrement, shift left/right,
// push, pop and error clear.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   data_in  : LOAD operand
//   op       : opcode (acc_pkg::op_t encoding, 10-15 behave as NOP)
//   data_out : registered accumulator
//   carry    : registered carry/borrow/shifted-out bit
//   zero     : data_out == 0
//   count    : registered stack occupancy
//   full     : count == DEPTH
//   empty    : count == 0
//   err      : sticky stack overflow/underflow flag
module acc_stack
   import acc_pkg::*;
#(
   parameter int WIDTH = ACC_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           data_in,
   input  logic [3:0]                 op,
   output logic [WIDTH-1:0]           data_out,
   output logic                       carry,
   output logic                       zero,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   op_t              opCode;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] accNext;
   logic             carryNext;
   logic [CW-1:0]    countNext;
   logic             errNext;
   logic [WIDTH:0]   incSum;
   logic             memWe;
   logic [AW-1:0]    memWaddr;
   logic [AW-1:0]    memRaddr;
   logic [WIDTH-1:0] memRdata;

   assign opCode   = op_t'(op);
   assign incSum   = {1'b0, acc} + {{WIDTH{1'b0}}, 1'b1};
   assign memWaddr = AW'(count);
   assign memRaddr = AW'(count - CW'(1));
   assign memWe    = (opCode == OP_PUSH) && !full;

   assign data_out = acc;
   assign zero     = (acc == '0);
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   acc_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) uMem (
      .clk   (clk),
      .we    (memWe),
      .waddr (memWaddr),
      .wdata (acc),
      .raddr (memRaddr),
      .rdata (memRdata)
   );

   // Opcode decode and datapath. Everything holds by default; illegal
   // push/pop only raise err and leave acc and count alone. Unlisted
   // encodings fall into the default branch and behave as NOP.
   always_comb begin
      accNext   = acc;
      carryNext = carry;
      countNext = count;
      errNext   = err;
      case (opCode)
         OP_LOAD: begin
            accNext = data_in;
         end
         OP_CLEAR: begin
            accNext   = '0;
            carryNext = 1'b0;
         end
         OP_INC: begin
            {carryNext, accNext} = incSum;
         end
         OP_DEC: begin
            accNext   = acc - WIDTH'(1);
            carryNext = (acc == '0);
         end
         OP_SHL: begin
            carryNext = acc[WIDTH-1];
            accNext   = {acc[WIDTH-2:0], 1'b0};
         end
         OP_SHR: begin
            carryNext = acc[0];
            accNext   = {1'b0, acc[WIDTH-1:1]};
         end
         OP_PUSH: begin
            if (full) begin
               errNext = 1'b1;
            end else begin
               countNext = count + CW'(1);
            end
         end
         OP_POP: begin
            if (empty) begin
               errNext = 1'b1;
            end else begin
               accNext   = memRdata;
               countNext = count - CW'(1);
            end
         end
         OP_CLRERR: begin
            errNext = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // State register; reset wins over whatever op is presented that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         carry <= 1'b0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         acc   <= accNext;
         carry <= carryNext;
         count <= countNext;
         err   <= errNext;
      end
   end

endmodule
